pac_dir_ctrl: RTL and testbench
===============================

PAC_DIR_CTRL -- requirements
Module: pac_dir_ctrl

Interface
REQ-001 Parameters SHALL be: STEP, default 1, motion magnitude in pixels per frame; TILE_LOG2, default 3, log2 of tile size in pixels (8-pixel tiles); TILE_OFS, default 4, pixel offset of the tile centre within a tile; BUF_FRAMES, default 15, number of frames a buffered turn request is kept.
REQ-002 Ports SHALL be, in order:
  frame_clk  in  1  frame clock (~60 Hz), all state updates on rising edge
  Reset  in  1  synchronous, active-high reset
  keycode  in  8  USB HID keycode of the held key, 0 = none
  PosX  in  10  current sprite X position from the motion stage
  PosY  in  10  current sprite Y position from the motion stage
  blk_up, blk_down, blk_left, blk_right  in  1 each  wall present in the adjacent tile in that direction
  MotionX  out  10  two's-complement X step per frame, feeds the motion stage
  MotionY  out  10  two's-complement Y step per frame, feeds the motion stage
  Dir  out  3  current direction: 0 IDLE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT
  turn_pending  out  1  a buffered request is held
REQ-003 Reset SHALL be Reset, synchronous, active-high; the clock SHALL be frame_clk.

Function
REQ-004 Keycode decode SHALL map 0x1A/0x52 to UP, 0x16/0x51 to DOWN, 0x04/0x50 to LEFT, and 0x07/0x4F to RIGHT; any other value, including 0, SHALL decode to no request.
REQ-005 Effective request each frame SHALL be the decoded key if valid, else the pending buffer; a valid key SHALL overwrite the pending buffer and reload the timer to BUF_FRAMES on the same edge.
REQ-006 Without a valid key, the timer SHALL decrement by 1 per frame while nonzero; the edge on which it reaches 0 SHALL clear the pending buffer.
REQ-007 Direction register SHALL be a 5-state FSM (IDLE, UP, DOWN, LEFT, RIGHT), updated once per frame_clk edge.
REQ-008 Aligned-X SHALL mean PosX[TILE_LOG2-1:0]==TILE_OFS; aligned-Y SHALL mean PosY[TILE_LOG2-1:0]==TILE_OFS.
REQ-009 IDLE -> requested direction SHALL be taken immediately if the blk_* flag for that direction is 0, with no alignment check.
REQ-010 Reversal (request opposite to the current direction) SHALL be taken immediately, with no alignment check, if the target blk_* flag is 0.
REQ-011 Perpendicular turn to UP/DOWN SHALL require aligned-X; a turn to LEFT/RIGHT SHALL require aligned-Y; the target blk_* flag SHALL also be 0.
REQ-012 A request rejected under REQ-009..011 SHALL remain pending until the timer expires or the request is taken.
REQ-013 A request equal to the current direction SHALL clear the buffer and leave the direction unchanged.
REQ-014 A taken request SHALL clear the pending buffer and the timer on the same edge.
REQ-015 While moving, if the current-direction blk_* flag is 1 and the sprite is aligned on the moving axis (aligned-Y for UP/DOWN, aligned-X for LEFT/RIGHT), the FSM SHALL go to IDLE unless a turn is taken on that edge; a turn SHALL take priority over the stop.
REQ-016 When blocked but not aligned, the FSM SHALL continue moving.
REQ-017 MotionX/MotionY SHALL be registered and SHALL reflect the new direction on the same edge the Dir register updates.
REQ-018 Motion values SHALL be: UP gives MotionY = -STEP; DOWN gives +STEP; LEFT gives MotionX = -STEP; RIGHT gives +STEP. The other axis and IDLE SHALL be 0. Negatives SHALL be 10-bit two's complement (-1 = 0x3FF).
REQ-019 turn_pending SHALL equal (timer != 0).

Reset
REQ-020 Reset SHALL set Dir=IDLE, MotionX=MotionY=0, clear the pending buffer, set timer=0 and turn_pending=0, overriding all other inputs.
REQ-021 Reset asserted mid-turn or mid-buffer SHALL discard the request; no carry-over after deassertion.

Verification
REQ-022 Reset, then keycode=0x07 with blk_right=0 -> after 1 edge Dir=4, MotionX=0x001, MotionY=0.
REQ-023 Moving RIGHT, PosY=0x0F3 (not aligned), keycode=0x1A one frame then 0 -> Dir stays 4, turn_pending=1. Set PosY=0x0F4 within 15 frames, with PosX aligned -> Dir=1, MotionY=0x3FF, turn_pending=0.
REQ-024 Buffered request never aligned -> turn_pending drops after exactly 15 frames without a key; Dir unchanged.
REQ-025 Moving RIGHT, blk_right=1, PosX=0x0A4 -> Dir=0 and Motion=0 next edge. Same with PosX=0x0A5 -> Dir stays 4.
REQ-026 Moving LEFT, keycode=0x4F at an unaligned PosX -> Dir=4 next edge. Reset asserted while turn_pending=1 -> all outputs 0 and stay 0 after deassertion with keycode=0.

Source files
------------

// File: rtl/pac_dir_ctrl.sv
// pac_dir_ctrl: per-frame direction controller for a tile-based maze sprite.
// Latency: one frame_clk edge from key/position inputs to Dir, MotionX, MotionY and turn_pending.
// No backpressure: the controller evaluates every frame; a rejected turn is buffered for BUF_FRAMES frames.
// Ports: frame_clk/Reset (sync, active-high); keycode (HID key held, 0 = none);
//   PosX/PosY sprite position; blk_up/down/left/right (wall in the adjacent tile);
//   MotionX/MotionY signed per-frame step; Dir (0 idle,1 up,2 down,3 left,4 right);
//   turn_pending (a buffered request is held).
module pac_dir_ctrl #(
  parameter int STEP       = 1,
  parameter int TILE_LOG2  = 3,
  parameter int TILE_OFS   = 4,
  parameter int BUF_FRAMES = 15
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] PosX,
  input  logic [9:0] PosY,
  input  logic       blk_up,
  input  logic       blk_down,
  input  logic       blk_left,
  input  logic       blk_right,
  output logic [9:0] MotionX,
  output logic [9:0] MotionY,
  output logic [2:0] Dir,
  output logic       turn_pending
);

  localparam logic [2:0] D_IDLE  = 3'd0;
  localparam logic [2:0] D_UP    = 3'd1;
  localparam logic [2:0] D_DOWN  = 3'd2;
  localparam logic [2:0] D_LEFT  = 3'd3;
  localparam logic [2:0] D_RIGHT = 3'd4;

  localparam int TW = (BUF_FRAMES < 2) ? 1 : $clog2(BUF_FRAMES + 1);
  localparam logic [TW-1:0]        BUF_LOAD = TW'(BUF_FRAMES);
  localparam logic [9:0]           STEP_P   = 10'(STEP);
  localparam logic [9:0]           STEP_N   = 10'(-STEP);
  localparam logic [TILE_LOG2-1:0] OFS      = TILE_LOG2'(TILE_OFS);

  logic [2:0]    pend_dir;
  logic [TW-1:0] timer;

  logic [2:0]    key_dir;
  logic [2:0]    eff_dir;
  logic [2:0]    next_dir;
  logic [2:0]    next_pend;
  logic [TW-1:0] next_timer;
  logic [9:0]    next_mx;
  logic [9:0]    next_my;
  logic          aligned_x;
  logic          aligned_y;
  logic          eff_blk;
  logic          cur_blk;
  logic          eff_align;
  logic          cur_align;
  logic          take;
  logic          stop;

  // Only the in-tile offset bits matter for alignment.
  logic unused_pos;
  assign unused_pos = ^{PosX[9:TILE_LOG2], PosY[9:TILE_LOG2]};

  assign aligned_x = (PosX[TILE_LOG2-1:0] == OFS);
  assign aligned_y = (PosY[TILE_LOG2-1:0] == OFS);

  function automatic logic blk_of(input logic [2:0] d, input logic bu, input logic bd,
                                  input logic bl, input logic br);
    case (d)
      D_UP:    blk_of = bu;
      D_DOWN:  blk_of = bd;
      D_LEFT:  blk_of = bl;
      D_RIGHT: blk_of = br;
      default: blk_of = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      D_UP:    opposite = D_DOWN;
      D_DOWN:  opposite = D_UP;
      D_LEFT:  opposite = D_RIGHT;
      D_RIGHT: opposite = D_LEFT;
      default: opposite = D_IDLE;
    endcase
  endfunction

  always_comb begin
    key_dir = D_IDLE;
    case (keycode)
      8'h1A, 8'h52: key_dir = D_UP;
      8'h16, 8'h51: key_dir = D_DOWN;
      8'h04, 8'h50: key_dir = D_LEFT;
      8'h07, 8'h4F: key_dir = D_RIGHT;
      default:      key_dir = D_IDLE;
    endcase
  end

  // A live key always wins over the buffer; the buffer only counts while the timer runs.
  assign eff_dir = (key_dir != D_IDLE) ? key_dir :
                   ((timer != '0) ? pend_dir : D_IDLE);

  assign eff_blk = blk_of(eff_dir, blk_up, blk_down, blk_left, blk_right);
  assign cur_blk = blk_of(Dir, blk_up, blk_down, blk_left, blk_right);

  // Vertical targets need to be centred in X, horizontal targets centred in Y.
  assign eff_align = (eff_dir == D_UP || eff_dir == D_DOWN) ? aligned_x : aligned_y;
  // Stopping against a wall happens at the tile centre along the axis of travel.
  assign cur_align = (Dir == D_UP || Dir == D_DOWN) ? aligned_y : aligned_x;

  assign take = (eff_dir != D_IDLE) && (eff_dir != Dir) && !eff_blk &&
                ((Dir == D_IDLE) || (eff_dir == opposite(Dir)) || eff_align);
  assign stop = !take && (Dir != D_IDLE) && cur_blk && cur_align;

  always_comb begin
    next_dir   = Dir;
    next_pend  = pend_dir;
    next_timer = timer;
    if (take) begin
      next_dir   = eff_dir;
      next_pend  = D_IDLE;
      next_timer = '0;
    end else begin
      if (stop) begin
        next_dir = D_IDLE;
      end
      if (eff_dir != D_IDLE && eff_dir == Dir) begin
        next_pend  = D_IDLE;
        next_timer = '0;
      end else if (key_dir != D_IDLE) begin
        next_pend  = key_dir;
        next_timer = BUF_LOAD;
      end else if (timer != '0) begin
        next_timer = timer - 1'b1;
        if (timer == TW'(1)) begin
          next_pend = D_IDLE;
        end
      end
    end
  end

  always_comb begin
    next_mx = '0;
    next_my = '0;
    case (next_dir)
      D_UP:    next_my = STEP_N;
      D_DOWN:  next_my = STEP_P;
      D_LEFT:  next_mx = STEP_N;
      D_RIGHT: next_mx = STEP_P;
      default: ;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      Dir      <= D_IDLE;
      MotionX  <= '0;
      MotionY  <= '0;
      pend_dir <= D_IDLE;
      timer    <= '0;
    end else begin
      Dir      <= next_dir;
      MotionX  <= next_mx;
      MotionY  <= next_my;
      pend_dir <= next_pend;
      timer    <= next_timer;
    end
  end

  assign turn_pending = (timer != '0);

endmodule

// File: tb/tb_pac_dir_ctrl.sv
module tb_pac_dir_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = '0;
  logic [9:0] PosX = '0;
  logic [9:0] PosY = '0;
  logic       blk_up = 1'b0, blk_down = 1'b0, blk_left = 1'b0, blk_right = 1'b0;
  logic [9:0] MotionX, MotionY;
  logic [2:0] Dir;
  logic       turn_pending;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [2:0] d;
    logic [9:0] mx;
    logic [9:0] my;
    logic       tp;
  } exp_t;

  exp_t exp_q[$];

  pac_dir_ctrl dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .keycode(keycode),
    .PosX(PosX),
    .PosY(PosY),
    .blk_up(blk_up),
    .blk_down(blk_down),
    .blk_left(blk_left),
    .blk_right(blk_right),
    .MotionX(MotionX),
    .MotionY(MotionY),
    .Dir(Dir),
    .turn_pending(turn_pending)
  );

  always #5 frame_clk = ~frame_clk;

  // Drive one frame's inputs away from the edge, then let the edge happen.
  task automatic drive(input logic [7:0] k, input logic [9:0] px, input logic [9:0] py,
                       input logic [3:0] blk, input logic rst);
    @(negedge frame_clk);
    keycode = k;
    PosX    = px;
    PosY    = py;
    {blk_up, blk_down, blk_left, blk_right} = blk;
    Reset   = rst;
    @(posedge frame_clk);
  endtask

  task automatic expect_out(input string name, input logic [2:0] d, input logic [9:0] mx,
                            input logic [9:0] my, input logic tp);
    exp_t e;
    e.name = name; e.d = d; e.mx = mx; e.my = my; e.tp = tp;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs settle after each edge; compare against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Dir !== e.d) begin
          errors++;
          $display("FAIL %s: got Dir=%0d, want Dir=%0d", e.name, Dir, e.d);
        end
        if (MotionX !== e.mx) begin
          errors++;
          $display("FAIL %s: got MotionX=%h, want MotionX=%h", e.name, MotionX, e.mx);
        end
        if (MotionY !== e.my) begin
          errors++;
          $display("FAIL %s: got MotionY=%h, want MotionY=%h", e.name, MotionY, e.my);
        end
        if (turn_pending !== e.tp) begin
          errors++;
          $display("FAIL %s: got turn_pending=%b, want turn_pending=%b", e.name, turn_pending, e.tp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    drive(8'h00, 10'h0A1, 10'h0F3, 4'b0000, 1'b1);
    expect_out("reset_state", 3'd0, 10'h000, 10'h000, 1'b0);

    // Idle start to the right, no alignment needed.
    drive(8'h07, 10'h0A1, 10'h0F3, 4'b0000, 1'b0);
    expect_out("idle_to_right", 3'd4, 10'h001, 10'h000, 1'b0);

    // UP request while X unaligned is buffered.
    drive(8'h1A, 10'h0A1, 10'h0F3, 4'b0000, 1'b0);
    expect_out("up_buffered", 3'd4, 10'h001, 10'h000, 1'b1);
    drive(8'h00, 10'h0A1, 10'h0F3, 4'b0000, 1'b0);
    expect_out("up_still_pending", 3'd4, 10'h001, 10'h000, 1'b1);
    drive(8'h00, 10'h0A4, 10'h0F4, 4'b0000, 1'b0);
    expect_out("buffered_up_taken", 3'd1, 10'h000, 10'h3FF, 1'b0);

    // LEFT request while moving up with Y unaligned: expires after 15 frames.
    drive(8'h04, 10'h0A4, 10'h0F1, 4'b0000, 1'b0);
    expect_out("left_buffered", 3'd1, 10'h000, 10'h3FF, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      drive(8'h00, 10'h0A4, 10'h0F1, 4'b0000, 1'b0);
      expect_out($sformatf("buf_expire_%0d", i), 3'd1, 10'h000, 10'h3FF, (i < 15));
    end

    // Perpendicular turn to RIGHT with Y aligned.
    drive(8'h07, 10'h0A4, 10'h0F4, 4'b0000, 1'b0);
    expect_out("up_to_right", 3'd4, 10'h001, 10'h000, 1'b0);

    // Wall ahead: keep moving until centred, then stop.
    drive(8'h00, 10'h0A5, 10'h0F4, 4'b0001, 1'b0);
    expect_out("blocked_unaligned_moves", 3'd4, 10'h001, 10'h000, 1'b0);
    drive(8'h00, 10'h0A4, 10'h0F4, 4'b0001, 1'b0);
    expect_out("blocked_aligned_stops", 3'd0, 10'h000, 10'h000, 1'b0);

    // Start left, then reverse at an unaligned X.
    drive(8'h04, 10'h0A4, 10'h0F4, 4'b0001, 1'b0);
    expect_out("idle_to_left", 3'd3, 10'h3FF, 10'h000, 1'b0);
    drive(8'h4F, 10'h0A1, 10'h0F4, 4'b0000, 1'b0);
    expect_out("reverse_to_right", 3'd4, 10'h001, 10'h000, 1'b0);

    // Reversal into a wall is refused and buffered; same-direction key clears it.
    drive(8'h04, 10'h0A1, 10'h0F4, 4'b0010, 1'b0);
    expect_out("reverse_blocked", 3'd4, 10'h001, 10'h000, 1'b1);
    drive(8'h07, 10'h0A1, 10'h0F4, 4'b0000, 1'b0);
    expect_out("same_dir_clears", 3'd4, 10'h001, 10'h000, 1'b0);

    // Reset discards a buffered request.
    drive(8'h1A, 10'h0A1, 10'h0F4, 4'b0000, 1'b0);
    expect_out("pending_before_reset", 3'd4, 10'h001, 10'h000, 1'b1);
    drive(8'h00, 10'h0A1, 10'h0F4, 4'b0000, 1'b1);
    expect_out("reset_mid_buffer", 3'd0, 10'h000, 10'h000, 1'b0);
    drive(8'h00, 10'h0A4, 10'h0F4, 4'b0000, 1'b0);
    expect_out("no_carry_over", 3'd0, 10'h000, 10'h000, 1'b0);

    // Idle request into a wall waits, then goes once the wall clears.
    drive(8'h16, 10'h0A4, 10'h0F4, 4'b0100, 1'b0);
    expect_out("idle_down_blocked", 3'd0, 10'h000, 10'h000, 1'b1);
    drive(8'h00, 10'h0A4, 10'h0F4, 4'b0000, 1'b0);
    expect_out("idle_down_taken", 3'd2, 10'h000, 10'h001, 1'b0);

    // Unmapped keycode is ignored.
    drive(8'h55, 10'h0A4, 10'h0F1, 4'b0000, 1'b0);
    expect_out("invalid_key", 3'd2, 10'h000, 10'h001, 1'b0);

    // Turn takes priority over stopping at a wall.
    drive(8'h04, 10'h0A1, 10'h0F4, 4'b0100, 1'b0);
    expect_out("turn_beats_stop", 3'd3, 10'h3FF, 10'h000, 1'b0);

    @(negedge frame_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
